// File: rtl/alu.sv
// 32-bit ARM datapath ALU: combinational ADD/SUB/AND/ORR with NZCV flags,
// plus a registered snapshot of the last result and flags for debug/trace.
module alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic [WIDTH-1:0] ResultQ,
  output logic [3:0]       FlagsQ
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  // SUB shares the adder as a + ~b + 1; ALUControl[0] doubles as the carry-in.
  assign b_eff = ALUControl[0] ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ALUControl[0]};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (ALUControl)
      2'b00, 2'b01: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = ~(ALUControl[0] ^ a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      2'b10: result = a & b;
      2'b11: result = a | b;
      default: begin
        result = 'x;
        carry  = 1'bx;
        ovf    = 1'bx;
      end
    endcase
  end

  assign Result   = result;
  assign ALUFlags = {result[WIDTH-1], (result == '0), carry, ovf};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= Result;
      flags_q  <= ALUFlags;
    end
  end

  assign ResultQ = result_q;
  assign FlagsQ  = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: combinational ops/flags, snapshot regs, async reset.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  ALUControl;
  logic [31:0] Result;
  logic [3:0]  ALUFlags;
  logic [31:0] ResultQ;
  logic [3:0]  FlagsQ;

  int n_tests = 0;
  int n_fail  = 0;

  alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .Result     (Result),
    .ALUFlags   (ALUFlags),
    .ResultQ    (ResultQ),
    .FlagsQ     (FlagsQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    // Reset held low: registers stay zero across edges while comb path tracks inputs.
    reset = 1'b0; a = 32'd5; b = 32'd2; ALUControl = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (ResultQ !== 32'h0) begin
      $display("FAIL reset_resultq: got %h want %h", ResultQ, 32'h0); n_fail++;
    end
    n_tests++;
    if (FlagsQ !== 4'h0) begin
      $display("FAIL reset_flagsq: got %b want %b", FlagsQ, 4'b0000); n_fail++;
    end
    n_tests++;
    if (Result !== 32'd7) begin
      $display("FAIL reset_comb_result: got %h want %h", Result, 32'd7); n_fail++;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (ResultQ !== 32'h0) begin
      $display("FAIL release_before_edge: got %h want %h", ResultQ, 32'h0); n_fail++;
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (ResultQ !== 32'd7 || FlagsQ !== 4'b0000) begin
      $display("FAIL release_capture: got %h/%b want %h/%b", ResultQ, FlagsQ, 32'd7, 4'b0000);
      n_fail++;
    end
  endtask

  task automatic test_arith();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [1:0]  vop[8];
    logic [31:0] er [8];
    logic [3:0]  ef [8];
    va[0]=32'd5;        vb[0]=32'd2;        vop[0]=2'b00; er[0]=32'd7;        ef[0]=4'b0000;
    va[1]=32'd12;       vb[1]=32'd12;       vop[1]=2'b01; er[1]=32'h0;        ef[1]=4'b0110;
    va[2]=32'd3;        vb[2]=32'd5;        vop[2]=2'b01; er[2]=32'hFFFFFFFE; ef[2]=4'b1000;
    va[3]=32'h7FFFFFFF; vb[3]=32'd1;        vop[3]=2'b00; er[3]=32'h80000000; ef[3]=4'b1001;
    va[4]=32'hFFFFFFFF; vb[4]=32'd1;        vop[4]=2'b00; er[4]=32'h0;        ef[4]=4'b0110;
    va[5]=32'h80000000; vb[5]=32'd1;        vop[5]=2'b01; er[5]=32'h7FFFFFFF; ef[5]=4'b0011;
    va[6]=32'd9;        vb[6]=32'd4;        vop[6]=2'b01; er[6]=32'd5;        ef[6]=4'b0010;
    va[7]=32'h80000000; vb[7]=32'h80000000; vop[7]=2'b00; er[7]=32'h0;        ef[7]=4'b0111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; ALUControl = vop[i];
      #1;
      n_tests++;
      if (Result !== er[i] || ALUFlags !== ef[i]) begin
        $display("FAIL arith[%0d]: got %h/%b want %h/%b", i, Result, ALUFlags, er[i], ef[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_logic();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [1:0]  vop[4];
    logic [31:0] er [4];
    logic [3:0]  ef [4];
    va[0]=32'hF0F0F0F0; vb[0]=32'h0FF00FF0; vop[0]=2'b10; er[0]=32'h00F000F0; ef[0]=4'b0000;
    va[1]=32'hF0F0F0F0; vb[1]=32'h0FF00FF0; vop[1]=2'b11; er[1]=32'hFFF0FFF0; ef[1]=4'b1000;
    // Carry-producing ADD then AND: C and V must drop to 0.
    va[2]=32'hFFFFFFFF; vb[2]=32'h00000001; vop[2]=2'b00; er[2]=32'h0;        ef[2]=4'b0110;
    va[3]=32'hFFFFFFFF; vb[3]=32'hFFFFFFFF; vop[3]=2'b10; er[3]=32'hFFFFFFFF; ef[3]=4'b1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; ALUControl = vop[i];
      #1;
      n_tests++;
      if (Result !== er[i] || ALUFlags !== ef[i]) begin
        $display("FAIL logic[%0d]: got %h/%b want %h/%b", i, Result, ALUFlags, er[i], ef[i]);
        n_fail++;
      end
    end
    @(negedge clk);
    a = 32'h0000FF00; b = 32'h000000FF; ALUControl = 2'b10;
    #1;
    n_tests++;
    if (Result !== 32'h0 || ALUFlags !== 4'b0100) begin
      $display("FAIL and_zero: got %h/%b want %h/%b", Result, ALUFlags, 32'h0, 4'b0100);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [1:0]  vop[4];
    logic [31:0] er [4];
    logic [3:0]  ef [4];
    va[0]=32'd5;        vb[0]=32'd2;  vop[0]=2'b00; er[0]=32'd7;        ef[0]=4'b0000;
    va[1]=32'd3;        vb[1]=32'd5;  vop[1]=2'b01; er[1]=32'hFFFFFFFE; ef[1]=4'b1000;
    va[2]=32'h7FFFFFFF; vb[2]=32'd1;  vop[2]=2'b00; er[2]=32'h80000000; ef[2]=4'b1001;
    va[3]=32'hF0F0F0F0; vb[3]=32'h0;  vop[3]=2'b11; er[3]=32'hF0F0F0F0; ef[3]=4'b1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; ALUControl = vop[i];
      @(posedge clk);
      #1;
      // Change inputs right after the edge; the snapshot must hold the captured value.
      a = 32'h0; b = 32'h0; ALUControl = 2'b00;
      #1;
      n_tests++;
      if (ResultQ !== er[i] || FlagsQ !== ef[i]) begin
        $display("FAIL snapshot[%0d]: got %h/%b want %h/%b", i, ResultQ, FlagsQ, er[i], ef[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 32'd5; b = 32'd2; ALUControl = 2'b00;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (ResultQ !== 32'h0 || FlagsQ !== 4'h0) begin
      $display("FAIL reset_mid: got %h/%b want %h/%b", ResultQ, FlagsQ, 32'h0, 4'b0000);
      n_fail++;
    end
    n_tests++;
    if (Result !== 32'd7) begin
      $display("FAIL reset_mid_comb: got %h want %h", Result, 32'd7); n_fail++;
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (ResultQ !== 32'h0) begin
      $display("FAIL reset_mid_hold: got %h want %h", ResultQ, 32'h0); n_fail++;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; a = '0; b = '0; ALUControl = 2'b00;
    test_reset();
    test_arith();
    test_logic();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the single-cycle ARM datapath; sits between the SrcA/SrcB operand muxes and the result mux / condition logic.
- Computes ADD, SUB, AND and ORR, plus the NZCV flags that condlogic consumes.
- Result and flags are combinational, so they are usable in the same cycle (address generation, branch target, writeback).
- A registered snapshot of the last result and flags is also provided for debug and trace.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  clock; snapshot registers update on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears the snapshot registers only.
- a  input  WIDTH  operand A (SrcA).
- b  input  WIDTH  operand B (SrcB).
- ALUControl  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- Result  output  WIDTH  combinational operation result.
- ALUFlags  output  4  combinational flags {N,Z,C,V}; bit3 = N, bit0 = V.
- ResultQ  output  WIDTH  Result registered on the previous rising clk edge.
- FlagsQ  output  4  ALUFlags registered on the previous rising clk edge.

Behaviour:
- Combinational path, zero latency, no clock dependence:
  - 00 ADD: compute sum = a + b with a (WIDTH+1)-bit adder; Result = sum[WIDTH-1:0].
  - 01 SUB: compute a + ~b + 1 in the same adder; Result = low WIDTH bits.
  - 10 AND: Result = a & b.
  - 11 ORR: Result = a | b.
  - ALUControl containing X/Z: Result = all-X, ALUFlags = all-X.
- Flags:
  - N = Result[WIDTH-1], for all ops.
  - Z = 1 iff Result == 0, for all ops.
  - C: ADD/SUB = carry out of the adder, bit WIDTH. For SUB, C = 1 means no borrow (a >= b unsigned). AND/ORR: C = 0.
  - V: ADD/SUB = signed overflow, i.e. operands-to-adder have equal sign bits and the result sign differs. Equivalently V = ~(ALUControl[0] ^ a[msb] ^ b[msb]) & (a[msb] ^ Result[msb]). AND/ORR: V = 0.
- Wrap-around: results are modulo 2^WIDTH. Examples:
  - 0xFFFFFFFF + 1 = 0, with Z = 1, C = 1, V = 0.
  - 0x7FFFFFFF + 1 = 0x80000000, with N = 1, V = 1, C = 0.
- SUB with a == b: Result = 0, Z = 1, C = 1.
- Registered path:
  - On every rising clk with reset high, ResultQ <= Result and FlagsQ <= ALUFlags.
  - No enable; capture is unconditional.
- Reset:
  - While reset is low, ResultQ = 0 and FlagsQ = 0 immediately (asynchronous), independent of clk.
  - Combinational outputs are unaffected by reset and keep tracking the inputs.
  - Release is synchronous in effect: the first capture happens on the first rising clk after reset goes high.
  - Reset asserted mid-cycle clears the registers at once; any pending capture is lost.
- Inputs changing in the same cycle as the clock edge: the captured value is the one settled before the edge (standard setup/hold). No internal state other than the snapshot registers.

Test Plan:
- ADD: a=5, b=2, ALUControl=00 -> Result=7, ALUFlags=0000; next clk edge -> ResultQ=7, FlagsQ=0000.
- SUB equal and borrow:
  - a=12, b=12, 01 -> Result=0, ALUFlags=0110 (Z, C).
  - a=3, b=5, 01 -> Result=0xFFFFFFFE, ALUFlags=1000.
- Overflow/carry:
  - a=0x7FFFFFFF, b=1, 00 -> Result=0x80000000, ALUFlags=1001.
  - a=0xFFFFFFFF, b=1, 00 -> Result=0, ALUFlags=0110.
  - a=0x80000000, b=1, 01 -> Result=0x7FFFFFFF, ALUFlags=0011.
- Logic ops:
  - a=0xF0F0F0F0, b=0x0FF00FF0, 10 -> Result=0x00F000F0, ALUFlags=0000.
  - Same operands, 11 -> Result=0xFFF0FFF0, ALUFlags=1000.
  - a=0xFFFFFFFF, b=0xFFFFFFFF, 10 after a carry-producing ADD -> C=0, V=0.
- Reset:
  - Hold reset low, drive a=5, b=2, ADD, toggle clk -> ResultQ=0, FlagsQ=0 throughout, while Result=7.
  - Release reset -> next rising edge ResultQ=7.
  - Pull reset low between edges -> ResultQ=0 with no clock edge.
